framebuffer_reader: RTL and testbench

Raster-order reader for the 4-bit-per-channel pixel framebuffer that the rasterizer fills. On a start pulse it sweeps every framebuffer address, issues memory reads, tolerates a fixed read latency, buffers returning pixels in a small FIFO, and presents them on a valid/ready pixel stream with coordinates and an end-of-frame marker. It sits between the framebuffer RAM read port and downstream consumers such as display scanout or frame capture.

---
 rtl/framebuffer_reader.sv | 194 +++++++++++++++++++
 tb/tb_framebuffer_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_reader.sv
// Raster-order framebuffer reader: sweeps every address, absorbs fixed RAM read
// latency and presents pixels with coordinates on a valid/ready stream.
module framebuffer_reader #(
  parameter int VERT_RESOLUTION  = 60,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int READ_LATENCY     = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_srst,
  input  logic                                  i_go,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [$clog2(VERT_RESOLUTION)-1:0]    o_vert_read_addr,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]   o_horiz_read_addr,
  output logic                                  o_read_en,
  input  logic [3:0]                            i_red,
  input  logic [3:0]                            i_green,
  input  logic [3:0]                            i_blue,
  output logic                                  o_pixel_valid,
  input  logic                                  i_pixel_ready,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]   o_pixel_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0]    o_pixel_y,
  output logic [3:0]                            o_red,
  output logic [3:0]                            o_green,
  output logic [3:0]                            o_blue,
  output logic                                  o_pixel_last
);

  localparam int XW = $clog2(HORIZ_RESOLUTION);
  localparam int YW = $clog2(VERT_RESOLUTION);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY) + 1;
  localparam logic [XW-1:0] X_MAX = XW'(HORIZ_RESOLUTION - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(VERT_RESOLUTION - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    READ  = 3'b010,
    DRAIN = 3'b100
  } state_t;

  typedef struct packed {
    logic          last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    red;
    logic [3:0]    green;
    logic [3:0]    blue;
  } pix_t;

  state_t        state, state_nxt;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          read_en, done, last_popped;

  logic          vld_p  [READ_LATENCY];
  logic [XW-1:0] x_p    [READ_LATENCY];
  logic [YW-1:0] y_p    [READ_LATENCY];
  logic          last_p [READ_LATENCY];

  pix_t          fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [FW:0]   fifo_cnt;
  logic          push, pop, head_vld;
  pix_t          push_pix, head;
  logic [CW-1:0] inflight_cnt, credit_use;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight_cnt = inflight_cnt + CW'(vld_p[i]);
  end

  assign head_vld = (fifo_cnt != '0);
  assign pop      = head_vld & i_pixel_ready;
  assign push     = vld_p[READ_LATENCY-1];
  // A head leaving this cycle returns its slot to the credit pool immediately,
  // which is what keeps the stream at one pixel per cycle for longer latencies.
  assign credit_use = inflight_cnt + CW'(fifo_cnt) - CW'(pop);

  always_comb begin
    state_nxt = state;
    read_en   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (i_go) state_nxt = READ;
      READ: begin
        read_en = (credit_use < CW'(FIFO_DEPTH));
        if (read_en && rd_x == X_MAX && rd_y == Y_MAX) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_popped && inflight_cnt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters stop on the final address; IDLE rewinds them for the next frame.
  always_ff @(posedge i_clk) begin
    if (i_srst || state == IDLE) begin
      rd_x <= '0;
      rd_y <= '0;
    end else if (read_en) begin
      if (rd_x != X_MAX) begin
        rd_x <= rd_x + 1'b1;
      end else if (rd_y != Y_MAX) begin
        rd_x <= '0;
        rd_y <= rd_y + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst || state == IDLE) last_popped <= 1'b0;
    else if (pop && head.last)   last_popped <= 1'b1;
  end

  // Stage p0..p(L-1): read tags travel alongside the RAM access
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= read_en;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    x_p[0]    <= rd_x;
    y_p[0]    <= rd_y;
    last_p[0] <= (rd_x == X_MAX) && (rd_y == Y_MAX);
    for (int i = 1; i < READ_LATENCY; i++) begin
      x_p[i]    <= x_p[i-1];
      y_p[i]    <= y_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  always_comb begin
    push_pix       = '0;
    push_pix.last  = last_p[READ_LATENCY-1];
    push_pix.x     = x_p[READ_LATENCY-1];
    push_pix.y     = y_p[READ_LATENCY-1];
    push_pix.red   = i_red;
    push_pix.green = i_green;
    push_pix.blue  = i_blue;
  end

  // FIFO stage: returning pixels, first-word fall-through head
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_pix;
  end

  // Outputs read as zero whenever no pixel is held, including right after reset.
  assign head = head_vld ? fifo_mem[rd_ptr] : '0;

  assign o_busy            = (state != IDLE) && !done;
  assign o_done            = done;
  assign o_read_en         = read_en;
  assign o_horiz_read_addr = rd_x;
  assign o_vert_read_addr  = rd_y;
  assign o_pixel_valid     = head_vld;
  assign o_pixel_x         = head.x;
  assign o_pixel_y         = head.y;
  assign o_red             = head.red;
  assign o_green           = head.green;
  assign o_blue            = head.blue;
  assign o_pixel_last      = head.last;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Scoreboard bench for framebuffer_reader: raster-order pixel model, RAM model
// with configurable latency, randomized backpressure, reset and go-pulse cases.
module tb_framebuffer_reader;

  localparam int H    = 80;
  localparam int V    = 60;
  localparam int NPIX = H * V;
  localparam int XW   = $clog2(H);
  localparam int YW   = $clog2(V);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    r;
    logic [3:0]    g;
    logic [3:0]    b;
    logic          last;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst, go, go3, ready;
  logic ready3 = 1'b1;

  logic          busy, done, read_en, pix_valid, pix_last;
  logic [YW-1:0] vaddr, pix_y;
  logic [XW-1:0] haddr, pix_x;
  logic [3:0]    red_in, green_in, blue_in, red_o, green_o, blue_o;

  logic          busy3, done3, read_en3, pix_valid3, pix_last3;
  logic [YW-1:0] vaddr3, pix_y3;
  logic [XW-1:0] haddr3, pix_x3;
  logic [3:0]    red_in3, green_in3, blue_in3, red_o3, green_o3, blue_o3;

  framebuffer_reader dut (
    .i_clk(clk), .i_srst(srst), .i_go(go), .o_busy(busy), .o_done(done),
    .o_vert_read_addr(vaddr), .o_horiz_read_addr(haddr), .o_read_en(read_en),
    .i_red(red_in), .i_green(green_in), .i_blue(blue_in),
    .o_pixel_valid(pix_valid), .i_pixel_ready(ready),
    .o_pixel_x(pix_x), .o_pixel_y(pix_y),
    .o_red(red_o), .o_green(green_o), .o_blue(blue_o), .o_pixel_last(pix_last)
  );

  framebuffer_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .i_clk(clk), .i_srst(srst), .i_go(go3), .o_busy(busy3), .o_done(done3),
    .o_vert_read_addr(vaddr3), .o_horiz_read_addr(haddr3), .o_read_en(read_en3),
    .i_red(red_in3), .i_green(green_in3), .i_blue(blue_in3),
    .o_pixel_valid(pix_valid3), .i_pixel_ready(ready3),
    .o_pixel_x(pix_x3), .o_pixel_y(pix_y3),
    .o_red(red_o3), .o_green(green_o3), .o_blue(blue_o3), .o_pixel_last(pix_last3)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel idx in raster order, RAM content {x, y, x^y} low nibbles.
  function automatic pix_t model_pix(input int idx);
    pix_t p;
    int px, py;
    px     = idx % H;
    py     = idx / H;
    p.x    = XW'(px);
    p.y    = YW'(py);
    p.r    = 4'(px);
    p.g    = 4'(py);
    p.b    = 4'(px ^ py);
    p.last = (idx == NPIX - 1);
    return p;
  endfunction

  function automatic pix_t pack_out(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                    input logic [3:0] r, input logic [3:0] g,
                                    input logic [3:0] b, input logic last);
    pix_t p;
    p.x = x; p.y = y; p.r = r; p.g = g; p.b = b; p.last = last;
    return p;
  endfunction

  pix_t exp_q[$];

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(model_pix(i));
  endtask

  // RAM models: address captured at the issuing edge, data shown L cycles later.
  logic          h_en  [4] = '{default: 1'b0};
  logic [XW-1:0] h_x   [4] = '{default: '0};
  logic [YW-1:0] h_y   [4] = '{default: '0};
  logic          h3_en [4] = '{default: 1'b0};
  logic [XW-1:0] h3_x  [4] = '{default: '0};
  logic [YW-1:0] h3_y  [4] = '{default: '0};
  logic          cap_en, cap3_en;
  logic [XW-1:0] cap_x, cap3_x;
  logic [YW-1:0] cap_y, cap3_y;

  always @(posedge clk) begin
    cap_en  = read_en;  cap_x  = haddr;  cap_y  = vaddr;
    cap3_en = read_en3; cap3_x = haddr3; cap3_y = vaddr3;
    #1;
    for (int i = 3; i > 0; i--) begin
      h_en[i]  = h_en[i-1];  h_x[i]  = h_x[i-1];  h_y[i]  = h_y[i-1];
      h3_en[i] = h3_en[i-1]; h3_x[i] = h3_x[i-1]; h3_y[i] = h3_y[i-1];
    end
    h_en[0]  = cap_en;  h_x[0]  = cap_x;  h_y[0]  = cap_y;
    h3_en[0] = cap3_en; h3_x[0] = cap3_x; h3_y[0] = cap3_y;
  end

  assign red_in    = h_en[0]  ? h_x[0][3:0]  : 4'hF;
  assign green_in  = h_en[0]  ? h_y[0][3:0]  : 4'hF;
  assign blue_in   = h_en[0]  ? (h_x[0][3:0] ^ h_y[0][3:0]) : 4'hF;
  assign red_in3   = h3_en[2] ? h3_x[2][3:0] : 4'hF;
  assign green_in3 = h3_en[2] ? h3_y[2][3:0] : 4'hF;
  assign blue_in3  = h3_en[2] ? (h3_x[2][3:0] ^ h3_y[2][3:0]) : 4'hF;

  // Backpressure: 0 = always ready, 1 = random 50%, 2 = never ready.
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ready = 1'b1;
      1:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted pixel of the L=1 instance.
  pix_t mon_cur, mon_exp, prev_pix;
  logic prev_stall = 1'b0;
  int   outstanding = 0;

  always @(negedge clk) begin
    mon_cur = pack_out(pix_x, pix_y, red_o, green_o, blue_o, pix_last);
    if (srst) begin
      exp_q.delete();
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({pix_valid, mon_cur}), 32'({1'b1, prev_pix}));
      if (read_en) outstanding++;
      if (pix_valid && ready) begin
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("pixel", 32'(mon_cur), 32'(mon_exp));
        end
        outstanding--;
      end
      check("occupancy_le_depth", 32'(outstanding <= 4), 32'(1));
      prev_stall = pix_valid && !ready;
      prev_pix   = mon_cur;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({busy, done, read_en, pix_valid, pix_last}), 32'(0));
    check({tag, "_pix"},  32'({pix_x, pix_y, red_o, green_o, blue_o}), 32'(0));
    check({tag, "_addr"}, 32'({vaddr, haddr}), 32'(0));
    check({tag, "_ctrl3"}, 32'({busy3, done3, read_en3, pix_valid3}), 32'(0));
  endtask

  int   first_k, done_k, done3_k, n_done, nreads, extra;
  logic done_seen;

  initial begin
    srst = 1'b1; go = 1'b0; go3 = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    srst = 1'b0;

    // Full frame, ready=1, both latencies side by side
    @(posedge clk); #1;
    go = 1'b1; go3 = 1'b1;
    push_frame();
    first_k = -1; done_k = -1; done3_k = -1; n_done = 0;
    for (int k = 1; k <= 4810; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        go = 1'b0; go3 = 1'b0;
        check("first_read", 32'({read_en, busy, vaddr, haddr}), 32'({1'b1, 1'b1, YW'(0), XW'(0)}));
        check("first_read3", 32'({read_en3, busy3}), 32'(2'b11));
      end
      if (pix_valid && first_k < 0) first_k = k;
      if (done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          check("busy_low_at_done", 32'(busy), 32'(0));
        end
      end
      if (done3 && done3_k < 0) done3_k = k;
      if (k == 4) check("l3_not_yet_valid", 32'(pix_valid3), 32'(0));
      if (k >= 5 && k < 5 + NPIX)
        check("l3_stream", 32'({pix_valid3, pack_out(pix_x3, pix_y3, red_o3, green_o3, blue_o3, pix_last3)}),
              32'({1'b1, model_pix(k - 5)}));
    end
    check("first_pixel_latency", 32'(first_k), 32'(3));
    check("done_cycle", 32'(done_k), 32'(NPIX + 3));
    check("done_count", 32'(n_done), 32'(1));
    check("done_cycle_l3", 32'(done3_k), 32'(NPIX + 5));
    check("frame1_drained", 32'(exp_q.size()), 32'(0));

    // Random backpressure, i_go pulsed during READ and on the o_done cycle
    rmode = 1;
    @(posedge clk); #1;
    go = 1'b1;
    push_frame();
    done_seen = 1'b0;
    for (int k = 1; k <= 20000 && !done_seen; k++) begin
      @(posedge clk); #1;
      go = (k >= 10 && k < 20) || done;
      if (done) begin
        done_seen = 1'b1;
        check("busy_low_at_done2", 32'(busy), 32'(0));
      end
    end
    check("frame2_done_seen", 32'(done_seen), 32'(1));
    @(posedge clk); #1;
    go = 1'b0;
    check("go_on_done_ignored", 32'({busy, read_en}), 32'(0));
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (read_en || done || busy) extra++;
    end
    check("no_second_frame", 32'(extra), 32'(0));
    check("frame2_drained", 32'(exp_q.size()), 32'(0));

    // Consumer never ready: only FIFO_DEPTH reads may be issued
    rmode = 2;
    @(posedge clk); #1;
    go = 1'b1;
    push_frame();
    nreads = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      go = 1'b0;
      if (read_en) begin
        check("bp_addr", 32'({vaddr, haddr}), 32'({YW'(0), XW'(nreads)}));
        nreads++;
      end
    end
    check("bp_read_count", 32'(nreads), 32'(4));
    check("bp_head", 32'({pix_valid, pix_x, pix_y}), 32'({1'b1, XW'(0), YW'(0)}));
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;

    // Reset mid-frame, then a clean frame from (0,0)
    rmode = 0;
    @(posedge clk); #1;
    go = 1'b1;
    push_frame();
    @(posedge clk); #1;
    go = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    go = 1'b1;
    push_frame();
    done_seen = 1'b0;
    for (int k = 1; k <= 6000 && !done_seen; k++) begin
      @(posedge clk); #1;
      go = 1'b0;
      if (done) done_seen = 1'b1;
    end
    check("frame4_done_seen", 32'(done_seen), 32'(1));
    check("frame4_drained", 32'(exp_q.size()), 32'(0));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
